// File: rtl/logic_op_sched_if.sv
// Request/grant/done bundle between the two requesters and the shared logic unit.
// The master side drives requests and operands. The slave side returns grants, results and status.
interface logic_op_sched_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             req0;
    logic             req1;
    logic [2:0]       op0;
    logic [2:0]       op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] res0;
    logic [WIDTH-1:0] res1;
    logic             busy;
    logic [CNT_W-1:0] op_cnt;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        input  gnt0, gnt1, done0, done1, res0, res1, busy, op_cnt
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        output gnt0, gnt1, done0, done1, res0, res1, busy, op_cnt
    );
endinterface

// File: rtl/logic_op_sched.sv
// Round-robin sequencer for one shared bitwise logic unit: gnt 1 cycle and done 2 cycles after the sampling edge.
// There is no stall path: requesters hold req until gnt, and a new request is sampled at most once every 3 cycles.
module logic_op_sched #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_op_sched_if.slave      bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             grant;
    logic             win;
    logic             win_q;
    logic             last_srv;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             done0_q;
    logic             done1_q;
    logic [WIDTH-1:0] res0_q;
    logic [WIDTH-1:0] res1_q;
    logic [CNT_W-1:0] op_cnt_q;

    // Arbitration is only evaluated in IDLE; on contention the port not served last wins.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = EXEC;
                    grant   = 1'b1;
                    win     = (bus.req0 && bus.req1) ? ~last_srv : bus.req1;
                end
            end
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result = '0;
        case (op_q)
            3'b000:  result = a_q & b_q;
            3'b001:  result = a_q | b_q;
            3'b010:  result = ~(a_q & b_q);
            3'b011:  result = ~(a_q | b_q);
            3'b100:  result = a_q ^ b_q;
            3'b101:  result = ~(a_q ^ b_q);
            3'b110:  result = ~a_q;
            default: result = a_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            last_srv <= 1'b1;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            res0_q   <= '0;
            res1_q   <= '0;
            op_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= grant && !win;
            gnt1_q  <= grant && win;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            if (grant) begin
                win_q    <= win;
                last_srv <= win;
                op_q     <= win ? bus.op1 : bus.op0;
                a_q      <= win ? bus.a1  : bus.a0;
                b_q      <= win ? bus.b1  : bus.b0;
            end
            if (state_q == EXEC) begin
                if (win_q) begin
                    res1_q  <= result;
                    done1_q <= 1'b1;
                end else begin
                    res0_q  <= result;
                    done0_q <= 1'b1;
                end
                op_cnt_q <= op_cnt_q + 1'b1;
            end
        end
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.res0   = res0_q;
    assign bus.res1   = res1_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.op_cnt = op_cnt_q;
endmodule

// File: tb/tb_logic_op_sched.sv
// Directed and random bench for logic_op_sched against a transaction-level model of the scheduler.
module tb_logic_op_sched;
    localparam int WIDTH = 32;
    localparam int CW    = 4;

    logic clk;
    logic rst;

    logic_op_sched_if #(.WIDTH(WIDTH), .CNT_W(CW)) bus ();

    logic_op_sched #(.WIDTH(WIDTH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          last_exp;
    logic [31:0] exp_res0;
    logic [31:0] exp_res1;
    logic [CW-1:0] exp_cnt;

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] status();
        return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy};
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst      = 1'b0;
        last_exp = 1'b1;
        exp_res0 = '0;
        exp_res1 = '0;
        exp_cnt  = '0;
    endtask

    // Called in IDLE, one time unit after an edge, with at least one req high.
    task automatic issue(input bit keep);
        logic [31:0] exp_r;
        int          w;
        if (bus.req0 && bus.req1) w = last_exp ? 0 : 1;
        else                      w = bus.req1 ? 1 : 0;
        exp_r = (w == 0) ? ref_op(bus.op0, bus.a0, bus.b0) : ref_op(bus.op1, bus.a1, bus.b1);
        @(posedge clk); #1;
        check("grant", 32'(status()), (w == 0) ? 32'b10001 : 32'b01001);
        last_exp = (w == 1);
        // Winner's operands change after the grant; the result must use the latched values.
        if (w == 0) begin
            bus.req0 = keep; bus.op0 = 3'($urandom); bus.a0 = $urandom; bus.b0 = $urandom;
        end else begin
            bus.req1 = keep; bus.op1 = 3'($urandom); bus.a1 = $urandom; bus.b1 = $urandom;
        end
        @(posedge clk); #1;
        if (w == 0) exp_res0 = exp_r;
        else        exp_res1 = exp_r;
        exp_cnt = exp_cnt + 1'b1;
        check("done", 32'(status()), (w == 0) ? 32'b00101 : 32'b00011);
        check("res0", bus.res0, exp_res0);
        check("res1", bus.res1, exp_res1);
        check("op_cnt", 32'(bus.op_cnt), 32'(exp_cnt));
        @(posedge clk); #1;
        check("back_idle", 32'(status()), 32'd0);
    endtask

    initial begin
        logic [31:0] av;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.op0 = 3'b100; bus.a0 = 32'hF0F0F0F0; bus.b0 = 32'hFF00FF00;
        bus.op1 = 3'b001; bus.a1 = 32'h0000FFFF; bus.b1 = 32'h12340000;
        rst = 1'b1;

        // Reset with both requests asserted
        @(posedge clk); @(posedge clk); #1;
        check("rst_status", 32'(status()), 32'd0);
        check("rst_res0", bus.res0, 32'd0);
        check("rst_res1", bus.res1, 32'd0);
        check("rst_cnt", 32'(bus.op_cnt), 32'd0);
        rst = 1'b0;
        last_exp = 1'b1; exp_res0 = '0; exp_res1 = '0; exp_cnt = '0;
        check("no_gnt_after_rst", 32'(status()), 32'd0);

        // Contention: port 0 first, then port 1, res0 held
        issue(1'b0);
        check("cont_res0", bus.res0, 32'h0FF00FF0);
        issue(1'b0);
        check("cont_res1", bus.res1, 32'h1234FFFF);
        check("cont_res0_held", bus.res0, 32'h0FF00FF0);

        // Reset during EXEC drops the operation
        do_reset(1);
        bus.req0 = 1'b1; bus.op0 = 3'b000; bus.a0 = $urandom; bus.b0 = $urandom;
        @(posedge clk); #1;
        check("mid_gnt", 32'(status()), 32'b10001);
        rst = 1'b1; bus.req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_status", 32'(status()), 32'd0);
        @(posedge clk); #1;
        check("mid_no_done", 32'(status()), 32'd0);
        check("mid_res0", bus.res0, 32'd0);
        check("mid_cnt", 32'(bus.op_cnt), 32'd0);

        // Single NAND on port 0
        bus.req0 = 1'b1; bus.op0 = 3'b010; bus.a0 = 32'hFFFFFFFF; bus.b0 = 32'hFFFFFFFF;
        issue(1'b0);
        check("nand_ones", bus.res0, 32'h00000000);
        check("nand_cnt", 32'(bus.op_cnt), 32'd1);
        bus.req0 = 1'b1; bus.op0 = 3'b010; bus.a0 = 32'h0; bus.b0 = 32'h007FA509;
        issue(1'b0);
        check("nand_zero", bus.res0, 32'hFFFFFFFF);

        // Port 1 NOT and pass
        bus.req1 = 1'b1; bus.op1 = 3'b110; bus.a1 = 32'h13579BDF; bus.b1 = $urandom;
        issue(1'b0);
        check("not_p1", bus.res1, 32'hECA86420);
        bus.req1 = 1'b1; bus.op1 = 3'b111; bus.a1 = 32'hA5A50F0F; bus.b1 = $urandom;
        issue(1'b0);
        check("pass_p1", bus.res1, 32'hA5A50F0F);

        // Fairness: both hold req for 6 operations, grants 0,1,0,1,0,1 every 3 cycles
        bus.req0 = 1'b1; bus.op0 = 3'($urandom); bus.a0 = $urandom; bus.b0 = $urandom;
        bus.req1 = 1'b1; bus.op1 = 3'($urandom); bus.a1 = $urandom; bus.b1 = $urandom;
        for (int i = 0; i < 6; i++) issue(1'b1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(posedge clk); #1;
        check("fair_idle", 32'(status()), 32'd0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(1, 3);
            bus.req0 = r[0]; bus.req1 = r[1];
            bus.op0 = 3'($urandom); bus.a0 = $urandom; bus.b0 = $urandom;
            bus.op1 = 3'($urandom); bus.a1 = $urandom; bus.b1 = $urandom;
            issue(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
                @(posedge clk); #1;
                check("rand_gap", 32'(status()), 32'd0);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Counter wrap through 15 -> 0 -> 1 with NOT/pass opcodes
        do_reset(2);
        for (int i = 1; i <= 17; i++) begin
            av = $urandom;
            bus.req0 = 1'b1; bus.op0 = (i % 2 == 1) ? 3'b110 : 3'b111;
            bus.a0 = av; bus.b0 = $urandom;
            issue(1'b0);
            check("wrap_cnt", 32'(bus.op_cnt), 32'(i % 16));
            check("wrap_res", bus.res0, (i % 2 == 1) ? ~av : av);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/logic_op_sched.md
# logic_op_sched

Sequencer and arbiter for a shared WIDTH-bit bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT/pass), which sits beside the core's gate-level IP blocks. Two requesters share the one unit through a req/gnt/done handshake with round-robin fairness. The block latches operands, runs one operation at a time through a 3-state FSM, and returns a registered result to the winning port. It also keeps a count of completed operations for debug.

## Interface
- WIDTH, 32, operand/result width in bits (≥1)
- CNT_W, 16, width of completed-operation counter
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  request from port 0 / 1; hold high with op/a/b stable until gnt seen
- op0 / op1  in  3  operation code for port 0 / 1
- a0, b0 / a1, b1  in  WIDTH  operands for port 0 / 1
- gnt0 / gnt1  out  1  one-cycle accept pulse, registered
- done0 / done1  out  1  one-cycle result-valid pulse, registered
- res0 / res1  out  WIDTH  result register per port, held until that port's next completion
- busy  out  1  high whenever FSM is not IDLE
- op_cnt  out  CNT_W  number of completed operations, wraps modulo 2^CNT_W

## Operation
- Opcodes: 000 a&b, 001 a|b, 010 ~(a&b), 011 ~(a|b), 100 a^b, 101 ~(a^b), 110 ~a (b ignored), 111 a (b ignored).
- FSM states and transitions:
  - IDLE: if req0|req1 → EXEC; else stay.
  - EXEC → DONE unconditionally.
  - DONE → IDLE unconditionally.
- Arbitration happens in IDLE only:
  - Only one req high: that port wins.
  - Both high: the port not equal to last_srv wins.
- last_srv updates only on a grant. Reset value is 1, so port 0 wins the first contention.
- On IDLE→EXEC edge: latch winner id, op, a, b into internal registers. Assert gnt of the winner for the EXEC cycle.
- On EXEC→DONE edge: compute result from latched op/a/b into res of the winner.
  - Assert done of the winner for the DONE cycle.
  - Increment op_cnt; it wraps from all-ones to 0.
  - res of the other port is unchanged.
- Inputs are ignored outside IDLE. Changes to op/a/b after the grant edge do not affect the result.
- A requester may hold req high through DONE to issue a back-to-back request. It is re-arbitrated in the next IDLE.
- Reset values: state IDLE, gnt0=gnt1=done0=done1=0, res0=res1=0, busy=0, op_cnt=0, last_srv=1, latched operands 0.
- Reset asserted in any state (including EXEC/DONE) returns all of the above next edge. The in-flight operation is dropped: no done, no count.

## Timing
- Edge k samples req in IDLE.
- Cycle k..k+1: gnt=1, busy=1.
- Edge k+1: res valid; during cycle k+1..k+2, done=1.
- Edge k+2: back in IDLE, done=0.
- Request-to-done latency: 2 cycles after the sampling edge.
- Peak throughput: one operation per 3 cycles.
- gnt and done never both high on the same port in the same cycle. At most one of gnt0/gnt1 and at most one of done0/done1 is high in any cycle.
- busy = (state != IDLE), registered-state derived, with no combinational path from req.
- All outputs come straight from flops (busy may be decoded from state flops).

## Test plan
- Reset: hold rst 2 cycles with both req high → all outputs 0, busy 0, no gnt for the cycle after rst drops. First grant goes to port 0.
- Single NAND, port 0: a0=FFFFFFFF, b0=FFFFFFFF, op0=010 → gnt0 one cycle after the sampling edge, done0 one cycle later, res0=00000000, op_cnt=1. Repeat with a0=0, b0=007FA509 → res0=FFFFFFFF.
- Contention: req0 and req1 high together, op0=100 (a=F0F0F0F0, b=FF00FF00), op1=001 (a=0000FFFF, b=12340000).
  - Expect res0=0FF00FF0 first, then res1=1234FFFF three cycles later.
  - res0 must be held while port 1 completes.
- Fairness: both ports hold req high continuously for 6 operations → grants alternate 0,1,0,1,0,1 with exactly 3 cycles between grants.
- Reset mid-operation: assert rst during EXEC → no done pulse, res unchanged from 0, op_cnt unchanged from 0, FSM in IDLE next cycle.
- Counter wrap with CNT_W=4: 17 single-port ops → op_cnt sequence reaches 15, then 0, then 1. Opcodes 110/111 return ~a / a regardless of b.
